// File: rtl/dm_frame_ctrl.sv
// dm_frame_ctrl: UART frame parser driving a 5x7 multiplexed dot-matrix display.
// Ports: CLK system clock; reset async active-low; rx_data/rx_valid received byte strobe;
//        rowOut row drive and colOut one-hot column select (registered, zero while disabled);
//        dm_enabled display status; frame_ok/frame_err one-cycle commit/reject pulses.
module dm_frame_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] rowOut,
  output logic [4:0] colOut,
  output logic       dm_enabled,
  output logic       frame_ok,
  output logic       frame_err
);
  typedef enum logic [2:0] {IDLE, GET_LEN, GET_CMD, GET_PAY, DISCARD} state_t;
  localparam logic [7:0] SYNC = 8'h7E, C_EN = 8'hA8, C_DIS = 8'hA4, C_COL = 8'hAC;
  state_t      r_state, w_next;
  logic [7:0]  r_cnt, w_cnt, r_cmd;
  logic [4:0]  r_col;
  logic [31:0] r_to, r_div;
  logic [2:0]  r_idx;
  logic        r_en, w_en, r_ok, r_err, w_ok, w_err, w_wr, w_commit;
  logic [6:0]  r_buf [5];
  logic [6:0]  r_row;
  logic [4:0]  r_colsel;
  logic [7:0]  w_cmd;
  logic        w_last, w_legal, w_timeout, w_bad_col, w_wrap;
  assign w_last    = r_cnt == 8'd1;
  // SET_COL is only legal with exactly three frame bytes; r_cnt still holds LEN here
  assign w_legal   = rx_data == C_EN || rx_data == C_DIS || (rx_data == C_COL && r_cnt == 8'd3);
  assign w_timeout = r_state != IDLE && r_to == 32'(TIMEOUT_CYC - 1);
  // a one-byte frame commits straight from GET_CMD, before r_cmd is loaded
  assign w_cmd     = r_state == GET_CMD ? rx_data : r_cmd;
  assign w_bad_col = w_cmd == C_COL && r_col > 5'd4;
  assign w_wrap    = r_div == 32'(SCAN_DIV - 1);
  always_comb begin
    w_next   = r_state;
    w_cnt    = r_cnt;
    w_commit = 1'b0;
    w_err    = 1'b0;
    if (rx_valid) begin
      unique case (r_state)
        IDLE: w_next = rx_data == SYNC ? GET_LEN : IDLE;
        GET_LEN: begin
          w_cnt  = rx_data;
          w_err  = rx_data == 8'd0;
          w_next = rx_data == 8'd0 ? IDLE : GET_CMD;
        end
        GET_CMD: begin
          w_cnt    = r_cnt - 8'd1;
          w_commit = w_legal && w_last;
          w_err    = !w_legal && w_last;
          w_next   = w_last ? IDLE : w_legal ? GET_PAY : DISCARD;
        end
        GET_PAY: begin
          w_cnt    = r_cnt - 8'd1;
          w_commit = w_last;
          w_next   = w_last ? IDLE : GET_PAY;
        end
        DISCARD: begin
          w_cnt  = r_cnt - 8'd1;
          w_err  = w_last;
          w_next = w_last ? IDLE : DISCARD;
        end
        default: w_next = IDLE;
      endcase
    end else if (w_timeout) begin
      w_err  = 1'b1;
      w_next = IDLE;
    end
    w_ok  = w_commit && !w_bad_col;
    w_err = w_err || (w_commit && w_bad_col);
    w_wr  = w_ok && w_cmd == C_COL;
    w_en  = w_ok && w_cmd == C_EN ? 1'b1 : w_ok && w_cmd == C_DIS ? 1'b0 : r_en;
  end
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cmd    <= '0;
      r_col    <= '0;
      r_to     <= '0;
      r_en     <= 1'b0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
      r_div    <= '0;
      r_idx    <= '0;
      r_row    <= '0;
      r_colsel <= '0;
      for (int i = 0; i < 5; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_en    <= w_en;
      r_ok    <= w_ok;
      r_err   <= w_err;
      r_to    <= rx_valid || r_state == IDLE ? '0 : r_to + 32'd1;
      if (rx_valid && r_state == GET_CMD) r_cmd <= rx_data;
      // first payload byte of a three-byte frame carries the column
      if (rx_valid && r_state == GET_PAY && r_cnt == 8'd2) r_col <= rx_data[4:0];
      if (w_wr) r_buf[r_col[2:0]] <= rx_data[6:0];
      r_div    <= w_wrap ? '0 : r_div + 32'd1;
      r_idx    <= w_wrap ? (r_idx == 3'd4 ? 3'd0 : r_idx + 3'd1) : r_idx;
      r_colsel <= r_en ? 5'b1 << r_idx : '0;
      r_row    <= r_en ? r_buf[r_idx] : '0;
    end
  end
  assign rowOut     = r_row;
  assign colOut     = r_colsel;
  assign dm_enabled = r_en;
  assign frame_ok   = r_ok;
  assign frame_err  = r_err;
endmodule

// File: tb/tb_dm_frame_ctrl.sv
// tb_dm_frame_ctrl: randomized frame stimulus checked against a frame-level reference model.
module tb_dm_frame_ctrl;
  localparam int SD = 4, TO = 100;
  typedef logic [7:0] bq_t[$];
  logic CLK = 0, reset = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic [6:0] rowOut;
  logic [4:0] colOut;
  logic dm_enabled, frame_ok, frame_err;
  int n_cmp = 0, n_bad = 0, n_ok = 0, n_err = 0, n_both = 0;
  logic m_en;
  logic [6:0] m_buf [5];
  always #5 CLK = ~CLK;
  dm_frame_ctrl #(.SCAN_DIV(SD), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rowOut(rowOut), .colOut(colOut), .dm_enabled(dm_enabled),
    .frame_ok(frame_ok), .frame_err(frame_err)
  );
  always @(negedge CLK) begin
    if (frame_ok) n_ok++;
    if (frame_err) n_err++;
    if (frame_ok && frame_err) n_both++;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic send(logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    tick(1);
    rx_valid = 0;
  endtask
  task automatic model_reset();
    m_en = 0;
    for (int i = 0; i < 5; i++) m_buf[i] = 0;
  endtask
  // frame-level semantics: decide the outcome of a complete byte sequence
  task automatic model(input bq_t q, output int ok, output int err);
    logic [7:0] len, cmd, c;
    ok = 0;
    err = 0;
    if (q.size() < 2 || q[0] != 8'h7E) return;
    len = q[1];
    if (len == 0) begin err = 1; return; end
    cmd = q[2];
    if (cmd == 8'hA8) begin m_en = 1; ok = 1; end
    else if (cmd == 8'hA4) begin m_en = 0; ok = 1; end
    else if (cmd == 8'hAC && len == 3) begin
      c = q[3] & 8'h1F;
      if (c < 5) begin m_buf[c] = q[4][6:0]; ok = 1; end
      else err = 1;
    end else err = 1;
  endtask
  task automatic frame(string tag, bq_t q, int gmin, int gmax);
    int o0, e0, eo, ee;
    o0 = n_ok;
    e0 = n_err;
    foreach (q[i]) begin
      if (i > 0 && gmax > 0) tick($urandom_range(gmax, gmin));
      send(q[i]);
    end
    tick(3);
    model(q, eo, ee);
    chk({tag, "_ok"}, n_ok - o0, eo);
    chk({tag, "_err"}, n_err - e0, ee);
    chk({tag, "_en"}, dm_enabled, m_en);
  endtask
  task automatic scan_check(int n);
    int idx;
    repeat (n) begin
      @(negedge CLK);
      if (m_en) begin
        idx = -1;
        for (int i = 0; i < 5; i++) if (colOut == 5'(1 << i)) idx = i;
        chk("col_onehot", idx >= 0, 1);
        if (idx >= 0) chk("row", rowOut, m_buf[idx]);
      end else begin
        chk("col_off", colOut, 0);
        chk("row_off", rowOut, 0);
      end
    end
  endtask
  initial begin
    logic [4:0] cur;
    bq_t q;
    int j, o0, e0, len;
    logic [7:0] cmd;
    model_reset();
    tick(3);
    chk("rst_row", rowOut, 0);
    chk("rst_col", colOut, 0);
    chk("rst_en", dm_enabled, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    reset = 1;
    tick(2);
    scan_check(8);
    frame("enable", '{8'h7E, 8'h04, 8'hA8, 8'h00, 8'h00, 8'h00}, 0, 0);
    j = 0;
    cur = colOut;
    while (colOut == cur && j < 20) begin @(negedge CLK); j++; end
    for (int k = 0; k < 6; k++) begin
      cur = colOut;
      j = 0;
      while (colOut == cur && j < 20) begin @(negedge CLK); j++; end
      chk("col_period", j, SD);
      chk("col_next", colOut, cur == 5'b10000 ? 5'b00001 : cur << 1);
    end
    scan_check(12);
    frame("col0", '{8'h7E, 8'h03, 8'hAC, 8'h00, 8'h7F}, 0, 0);
    frame("col1", '{8'h7E, 8'h03, 8'hAC, 8'h01, 8'h7C}, 0, 0);
    frame("col2", '{8'h7E, 8'h03, 8'hAC, 8'h02, 8'h78}, 0, 0);
    frame("col3", '{8'h7E, 8'h03, 8'hAC, 8'h03, 8'h60}, 0, 0);
    frame("col4", '{8'h7E, 8'h03, 8'hAC, 8'h04, 8'h40}, 0, 0);
    scan_check(30);
    frame("badcol", '{8'h7E, 8'h03, 8'hAC, 8'h07, 8'h55}, 0, 0);
    frame("shortcol", '{8'h7E, 8'h02, 8'hAC, 8'h01}, 0, 0);
    frame("after_err", '{8'h7E, 8'h03, 8'hAC, 8'h02, 8'h11}, 0, 0);
    frame("data7e", '{8'h7E, 8'h03, 8'hAC, 8'h01, 8'h7E}, 0, 0);
    frame("unknown", '{8'h7E, 8'h05, 8'h55, 8'h11, 8'h22, 8'h33, 8'h44}, 0, 0);
    frame("stray", '{8'h12, 8'h34}, 0, 0);
    frame("len0", '{8'h7E, 8'h00}, 0, 0);
    frame("gap_edge", '{8'h7E, 8'h03, 8'hAC, 8'h03, 8'h2A}, TO - 1, TO - 1);
    scan_check(25);
    o0 = n_ok;
    e0 = n_err;
    send(8'h7E); send(8'h03); send(8'hAC);
    j = 0;
    while (!frame_err && j < 3 * TO) begin @(negedge CLK); j++; end
    chk("to_latency", j, TO + 1);
    tick(2);
    chk("to_err_cnt", n_err - e0, 1);
    chk("to_ok_cnt", n_ok - o0, 0);
    frame("after_to", '{8'h7E, 8'h03, 8'hAC, 8'h04, 8'h33}, 0, 0);
    scan_check(25);
    frame("disable", '{8'h7E, 8'h01, 8'hA4}, 0, 0);
    scan_check(10);
    frame("setcol_off", '{8'h7E, 8'h03, 8'hAC, 8'h00, 8'h15}, 0, 0);
    frame("reenable", '{8'h7E, 8'h01, 8'hA8}, 0, 0);
    scan_check(25);
    for (int f = 0; f < 150; f++) begin
      q.delete();
      if ($urandom_range(7) == 0) q.push_back(8'($urandom_range(8'h7D)));
      case ($urandom_range(5))
        0: cmd = 8'hA8;
        1: cmd = 8'hA4;
        2, 3, 4: cmd = 8'hAC;
        default: cmd = 8'($urandom);
      endcase
      len = cmd == 8'hAC ? ($urandom_range(3) == 0 ? $urandom_range(5) : 3) : $urandom_range(4);
      q.push_back(8'h7E);
      q.push_back(8'(len));
      if (q[0] != 8'h7E) frame("rnd_stray", q[0:0], 0, 0);
      if (q[0] != 8'h7E) void'(q.pop_front());
      if (len > 0) q.push_back(cmd);
      for (int i = 1; i < len; i++)
        q.push_back(i == 1 && cmd == 8'hAC ? 8'({$urandom_range(7), 5'($urandom_range(6))})
                    : $urandom_range(3) == 0 ? 8'h7E : 8'($urandom));
      frame("rnd", q, 0, 3);
      if (f % 5 == 0) scan_check(22);
    end
    send(8'h7E); send(8'h03); send(8'hAC);
    o0 = n_ok;
    e0 = n_err;
    reset = 0;
    #1;
    chk("mid_rst_row", rowOut, 0);
    chk("mid_rst_col", colOut, 0);
    chk("mid_rst_en", dm_enabled, 0);
    tick(3);
    chk("mid_rst_ok", frame_ok, 0);
    chk("mid_rst_err", frame_err, 0);
    reset = 1;
    model_reset();
    tick(1);
    send(8'h01); send(8'h7F);
    tick(3);
    chk("mid_rst_noks", n_ok - o0, 0);
    chk("mid_rst_nerrs", n_err - e0, 0);
    scan_check(10);
    frame("post_rst_en", '{8'h7E, 8'h01, 8'hA8}, 0, 0);
    scan_check(25);
    chk("ok_err_excl", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
